chan_ctlr_multi: RTL and testbench
==================================

Name: chan_ctlr_multi

Overview:
- Parametrised successor of the single-channel CHN command executor.
- Executes the CHN command modes: send, receive, query and address-convert.
- Adds per-channel receive FIFOs so bus messages arriving before the matching receive are buffered instead of lost.
- Sits between the ALU_BEGIN decode stage and the inter-CPU message bus; signals completion to the sequencer with cmd_done.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, address/channel-id width.
- MSG_W, 8, CPU message code width.
- CHAN_NUM, 4, number of receive channels (power of 2, 1..16).
- FIFO_DEPTH, 4, words per channel FIFO (power of 2, 2..16).
- TIMEOUT_CYC, 1024, receive-wait limit (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clk_oe  in  1  clock enable; state and FIFOs update only when 1.
- disp_online  in  1  dispatcher online; commands accepted only when 1.
- cmd_valid  in  1  CHN command present (state==ALU_BEGIN, cmd_code==CMD_CHN).
- mode  in  3  {regDen,regS0en,regS1en}.
- src0  in  ADDR_W  channel address.
- src1  in  DATA_W  send data / convert operand.
- base_addr_data  in  ADDR_W  thread data base.
- chan_base  in  ADDR_W  address of local channel 0.
- dst  out  DATA_W  result register.
- cmd_done  out  1  one-cycle completion pulse.
- cmd_err  out  1  one-cycle error pulse, coincident with cmd_done.
- msg_valid  out  1  outgoing message request.
- msg_ready  in  1  bus grant (not is_bus_busy).
- msg_code  out  MSG_W  CPU_R_CHAN_SET while msg_valid, else 0.
- msg_addr  out  ADDR_W  src0 while msg_valid, else 0.
- msg_data  out  DATA_W  src1 while msg_valid, else 0.
- in_valid  in  1  incoming message strobe.
- in_code  in  MSG_W  incoming message code.
- in_addr  in  ADDR_W  incoming channel address.
- in_data  in  DATA_W  incoming payload.
- ovf  out  CHAN_NUM  sticky per-channel overflow flags.

Behaviour:
- Reset (rst=0, asynchronous) forces: state IDLE; all FIFOs empty; dst=0; cmd_done=0; cmd_err=0; msg_valid=0; ovf=0.
- Every step below happens only in cycles with clk_oe=1. In cycles with clk_oe=0, cmd_done and cmd_err are forced to 0; nothing else changes.
- Channel hit: in_valid=1, in_code=CPU_R_CHAN_SET and (in_addr - chan_base) < CHAN_NUM, computed as an unsigned ADDR_W subtraction. The channel index is that difference.
- On a hit, the payload is pushed into that channel's FIFO.
- Push to a full FIFO: data is dropped and ovf[idx] is set, unless a pop of the same channel occurs in the same cycle; then the push is accepted.
- Non-hit messages are ignored. The bus never echoes this block's own messages.
- Commands are sampled in IDLE when cmd_valid=1 and disp_online=1. The channel index for receives is src0 - chan_base.
- State machine, mode 011 (send): IDLE -> SEND. msg_valid is held until a cycle with msg_ready=1. Then: msg_valid=0, cmd_done pulse, -> IDLE.
- Mode 111 (query): IDLE -> SEND, as for 011. After the grant -> RECV instead of done.
- Mode 110 (receive): IDLE -> RECV.
- RECV: when the channel FIFO is non-empty, pop, dst=head, cmd_done pulse, -> IDLE. With a non-empty FIFO, cmd_done fires 1 cycle after entering RECV. A same-cycle push to an empty FIFO becomes visible next cycle.
- Mode 101 (convert): dst = src1 + base_addr_data, truncated to DATA_W; cmd_done next cycle.
- Mode 000 (nop): clears all ovf bits; cmd_done next cycle; dst unchanged.
- Modes 100, 010, 001 (illegal): dst=0, cmd_done and cmd_err next cycle.
- Receive address not a local channel (index >= CHAN_NUM): dst=0, cmd_done and cmd_err, no wait.
- disp_online falling while in SEND or RECV: abort, msg_valid=0, dst=0, cmd_done and cmd_err, -> IDLE. FIFO contents are preserved.
- cmd_valid is ignored outside IDLE. The sequencer drops cmd_valid after cmd_done.
- FIFO read/write pointers wrap modulo FIFO_DEPTH. Occupancy uses a log2(FIFO_DEPTH)+1-bit count.

Optional Feature:
- CHAN_RX_TIMEOUT_EN defined: a counter runs in RECV. After TIMEOUT_CYC enabled cycles with the FIFO empty: dst=0, cmd_done and cmd_err pulse, -> IDLE.
- CHAN_RX_TIMEOUT_EN undefined: RECV waits indefinitely, and TIMEOUT_CYC is unused.

Test Plan:
- Reset with chan_base=0x100, then 3 hits on in_addr 0x102 with data 0xA1, 0xA2, 0xA3; receive mode 110, src0=0x102, three times -> dst 0xA1, 0xA2, 0xA3 in order, each with cmd_done and no cmd_err.
- 5 hits to channel 0 (FIFO_DEPTH=4) -> ovf=4'b0001, 5th word lost; mode 000 -> ovf=0.
- Send mode 011, src0=0x200, src1=0x55, msg_ready low for 3 cycles -> msg_valid held 3 cycles with code CPU_R_CHAN_SET, addr 0x200, data 0x55; cmd_done 1 cycle after the grant.
- Query mode 111 to 0x101, reply 0x77 injected 5 cycles after the grant -> dst=0x77, cmd_done 1 cycle after the push.
- Convert mode 101, src1=0x10, base_addr_data=0xFFFFFFF8 -> dst=0x8; illegal mode 100 -> dst=0, cmd_err=1.
- In RECV on an empty channel, drop disp_online -> cmd_err and IDLE. With CHAN_RX_TIMEOUT_EN and TIMEOUT_CYC=16 -> cmd_err after 16 enabled cycles.

Source files
------------

// File: rtl/chan_ctlr_multi.sv
// chan_ctlr_multi: CHN command executor (send / receive / query / address-convert) with per-channel receive FIFOs.
// Latency: convert, nop, illegal and bad-channel commands finish 1 cycle after acceptance; a receive finishes 1 cycle after data is in the FIFO.
// Backpressure: msg_valid is held until msg_ready; a push to a full channel FIFO drops the word and sets ovf for that channel.
//
// Optional feature macro: CHAN_RX_TIMEOUT_EN. When defined, a receive that waits TIMEOUT_CYC enabled cycles
// on an empty FIFO ends with cmd_done + cmd_err. When undefined, a receive waits indefinitely.
//
// Ports:
//   clk, rst (async, active-low), clk_oe (clock enable for all state and FIFOs)
//   disp_online, cmd_valid, mode, src0, src1, base_addr_data, chan_base : command side
//   dst, cmd_done, cmd_err                                               : result side
//   msg_valid/msg_ready, msg_code, msg_addr, msg_data                    : outgoing bus request
//   in_valid, in_code, in_addr, in_data                                  : incoming bus messages
//   ovf                                                                  : sticky per-channel overflow flags

// chan_fifo: single-channel receive FIFO with head-of-queue read.
// Latency: a pushed word is visible at head/count the cycle after the push.
// Backpressure: push to a full FIFO is discarded unless a pop happens in the same cycle.
module chan_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a push into a full FIFO is still accepted then.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

module chan_ctlr_multi #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MSG_W       = 8,
    parameter int CHAN_NUM    = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_oe,
    input  logic                disp_online,
    input  logic                cmd_valid,
    input  logic [2:0]          mode,
    input  logic [ADDR_W-1:0]   src0,
    input  logic [DATA_W-1:0]   src1,
    input  logic [ADDR_W-1:0]   base_addr_data,
    input  logic [ADDR_W-1:0]   chan_base,
    output logic [DATA_W-1:0]   dst,
    output logic                cmd_done,
    output logic                cmd_err,
    output logic                msg_valid,
    input  logic                msg_ready,
    output logic [MSG_W-1:0]    msg_code,
    output logic [ADDR_W-1:0]   msg_addr,
    output logic [DATA_W-1:0]   msg_data,
    input  logic                in_valid,
    input  logic [MSG_W-1:0]    in_code,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_data,
    output logic [CHAN_NUM-1:0] ovf
);
    localparam logic [MSG_W-1:0] CPU_R_CHAN_SET = MSG_W'(8'h0C);
    localparam int IW = (CHAN_NUM > 1) ? $clog2(CHAN_NUM) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_RECV = 2'd2;

    localparam logic [2:0] M_NOP   = 3'b000;
    localparam logic [2:0] M_SEND  = 3'b011;
    localparam logic [2:0] M_QUERY = 3'b111;
    localparam logic [2:0] M_RECV  = 3'b110;
    localparam logic [2:0] M_CONV  = 3'b101;

    logic [1:0]          state;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_data;
    logic                cmd_query;
    logic [IW-1:0]       rx_idx;
    logic                rx_local;

    logic [ADDR_W-1:0]   in_diff;
    logic [ADDR_W-1:0]   src_diff;
    logic                in_hit;
    logic                src_local;
    logic [IW-1:0]       in_idx;

    logic [CHAN_NUM-1:0] push_vec;
    logic [CHAN_NUM-1:0] pop_vec;
    logic [CHAN_NUM-1:0] drop_vec;
    logic [DATA_W-1:0]   fifo_head [CHAN_NUM];
    logic [CW-1:0]       fifo_cnt  [CHAN_NUM];

    logic                rx_nonempty;
    logic                pop_req;
    logic                accept;
    logic                ovf_clr;
    logic                tmo_hit;

    // Unsigned wrap-around subtraction: addresses below chan_base become huge and miss.
    assign in_diff   = in_addr - chan_base;
    assign src_diff  = src0 - chan_base;
    assign in_hit    = in_valid && (in_code == CPU_R_CHAN_SET) && (in_diff < ADDR_W'(CHAN_NUM));
    assign src_local = (src_diff < ADDR_W'(CHAN_NUM));
    assign in_idx    = in_diff[IW-1:0];

    assign rx_nonempty = (fifo_cnt[rx_idx] != '0);
    assign pop_req     = clk_oe && (state == S_RECV) && disp_online && rx_nonempty;
    // cmd_done still high means the sequencer has not yet dropped cmd_valid for the finished command.
    assign accept      = clk_oe && (state == S_IDLE) && cmd_valid && disp_online && !cmd_done;
    assign ovf_clr     = accept && (mode == M_NOP);

    assign msg_code = msg_valid ? CPU_R_CHAN_SET : '0;
    assign msg_addr = msg_valid ? cmd_addr       : '0;
    assign msg_data = msg_valid ? cmd_data       : '0;

    for (genvar c = 0; c < CHAN_NUM; c++) begin : g_chan
        assign push_vec[c] = clk_oe && in_hit && (in_idx == IW'(c));
        assign pop_vec[c]  = pop_req && (rx_idx == IW'(c));
        assign drop_vec[c] = push_vec[c] && (fifo_cnt[c] == CW'(FIFO_DEPTH)) && !pop_vec[c];

        chan_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push_vec[c]),
            .pop   (pop_vec[c]),
            .din   (in_data),
            .head  (fifo_head[c]),
            .count (fifo_cnt[c])
        );
    end

`ifdef CHAN_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt;

    // Counts enabled RECV cycles spent on an empty FIFO; cleared whenever the wait ends.
    assign tmo_hit = (state == S_RECV) && !rx_nonempty && (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (clk_oe) begin
            if ((state == S_RECV) && !rx_nonempty && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
            else                                                tmo_cnt <= '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Overflow flags: a drop in the same cycle as a nop wins so the new event is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= '0;
        end else if (clk_oe) begin
            ovf <= (ovf & ~{CHAN_NUM{ovf_clr}}) | drop_vec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            dst       <= '0;
            cmd_done  <= 1'b0;
            cmd_err   <= 1'b0;
            msg_valid <= 1'b0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            cmd_query <= 1'b0;
            rx_idx    <= '0;
            rx_local  <= 1'b0;
        end else if (!clk_oe) begin
            cmd_done <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            cmd_done <= 1'b0;
            cmd_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cmd_addr  <= src0;
                        cmd_data  <= src1;
                        cmd_query <= (mode == M_QUERY);
                        rx_idx    <= src_diff[IW-1:0];
                        rx_local  <= src_local;
                        case (mode)
                            M_SEND, M_QUERY: begin
                                msg_valid <= 1'b1;
                                state     <= S_SEND;
                            end
                            M_RECV: begin
                                if (src_local) begin
                                    state <= S_RECV;
                                end else begin
                                    dst      <= '0;
                                    cmd_done <= 1'b1;
                                    cmd_err  <= 1'b1;
                                end
                            end
                            M_CONV: begin
                                dst      <= src1 + DATA_W'(base_addr_data);
                                cmd_done <= 1'b1;
                            end
                            M_NOP: begin
                                cmd_done <= 1'b1;
                            end
                            default: begin
                                dst      <= '0;
                                cmd_done <= 1'b1;
                                cmd_err  <= 1'b1;
                            end
                        endcase
                    end
                end
                S_SEND: begin
                    if (!disp_online) begin
                        msg_valid <= 1'b0;
                        dst       <= '0;
                        cmd_done  <= 1'b1;
                        cmd_err   <= 1'b1;
                        state     <= S_IDLE;
                    end else if (msg_ready) begin
                        msg_valid <= 1'b0;
                        if (!cmd_query) begin
                            cmd_done <= 1'b1;
                            state    <= S_IDLE;
                        end else if (rx_local) begin
                            state <= S_RECV;
                        end else begin
                            // Query reply could never land in a local FIFO.
                            dst      <= '0;
                            cmd_done <= 1'b1;
                            cmd_err  <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                end
                S_RECV: begin
                    if (!disp_online) begin
                        dst      <= '0;
                        cmd_done <= 1'b1;
                        cmd_err  <= 1'b1;
                        state    <= S_IDLE;
                    end else if (rx_nonempty) begin
                        dst      <= fifo_head[rx_idx];
                        cmd_done <= 1'b1;
                        state    <= S_IDLE;
                    end else if (tmo_hit) begin
                        dst      <= '0;
                        cmd_done <= 1'b1;
                        cmd_err  <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chan_ctlr_multi.sv
// tb_chan_ctlr_multi: self-checking bench for chan_ctlr_multi (default parameters, timeout feature off).
// Latency: inputs are driven on the falling edge, outputs sampled on the falling edge.
// Backpressure: msg_ready is driven by the bench to model bus grants.
module tb_chan_ctlr_multi;
    localparam logic [7:0] CHAN_SET = 8'h0C;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_oe;
    logic        disp_online;
    logic        cmd_valid;
    logic [2:0]  mode;
    logic [31:0] src0;
    logic [31:0] src1;
    logic [31:0] base_addr_data;
    logic [31:0] chan_base;
    logic [31:0] dst;
    logic        cmd_done;
    logic        cmd_err;
    logic        msg_valid;
    logic        msg_ready;
    logic [7:0]  msg_code;
    logic [31:0] msg_addr;
    logic [31:0] msg_data;
    logic        in_valid;
    logic [7:0]  in_code;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [3:0]  ovf;

    always #5 clk = ~clk;

    chan_ctlr_multi dut (
        .clk            (clk),
        .rst            (rst),
        .clk_oe         (clk_oe),
        .disp_online    (disp_online),
        .cmd_valid      (cmd_valid),
        .mode           (mode),
        .src0           (src0),
        .src1           (src1),
        .base_addr_data (base_addr_data),
        .chan_base      (chan_base),
        .dst            (dst),
        .cmd_done       (cmd_done),
        .cmd_err        (cmd_err),
        .msg_valid      (msg_valid),
        .msg_ready      (msg_ready),
        .msg_code       (msg_code),
        .msg_addr       (msg_addr),
        .msg_data       (msg_data),
        .in_valid       (in_valid),
        .in_code        (in_code),
        .in_addr        (in_addr),
        .in_data        (in_data),
        .ovf            (ovf)
    );

    typedef struct packed {
        logic [31:0] dst;
        logic        err;
        logic [31:0] lat;
    } exp_t;

    typedef struct packed {
        logic [2:0]  m;
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] b;
        logic [31:0] dst;
        logic        err;
    } vec_t;

    exp_t sb[$];
    vec_t vt[12];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic inject(input logic [7:0] code, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = code;
        in_addr  = addr;
        in_data  = data;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Pushes the expectation when the command is driven; pops and compares on cmd_done.
    task automatic run_cmd(input string nm, input int idx, input logic [2:0] m, input logic [31:0] s0,
                           input logic [31:0] s1, input logic [31:0] b, input logic [31:0] e_dst,
                           input logic e_err, input int e_lat);
        exp_t e;
        int   lat;
        bit   seen;
        e.dst = e_dst;
        e.err = e_err;
        e.lat = 32'(e_lat);
        @(negedge clk);
        mode = m; src0 = s0; src1 = s1; base_addr_data = b; cmd_valid = 1'b1;
        sb.push_back(e);
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (cmd_done) seen = 1'b1;
        end
        cmd_valid = 1'b0;
        e = sb.pop_front();
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL %s[%0d]: cmd_done never seen, expected after %0d cycles", nm, idx, e.lat);
        end else begin
            check({nm, ".dst"}, idx, dst, e.dst);
            check({nm, ".err"}, idx, 32'(cmd_err), 32'(e.err));
            check({nm, ".lat"}, idx, 32'(lat), e.lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int  held;
        bit  early;
        bit  seen;

        vt[0]  = '{3'b101, 32'h0,   32'h10,       32'hFFFF_FFF8, 32'h8,        1'b0};
        vt[1]  = '{3'b000, 32'h0,   32'h0,        32'h0,         32'h8,        1'b0};
        vt[2]  = '{3'b101, 32'h0,   32'h1234_5678, 32'h1000,     32'h1234_6678, 1'b0};
        vt[3]  = '{3'b100, 32'h0,   32'h0,        32'h0,         32'h0,        1'b1};
        vt[4]  = '{3'b101, 32'h0,   32'h5,        32'h5,         32'hA,        1'b0};
        vt[5]  = '{3'b010, 32'h0,   32'h0,        32'h0,         32'h0,        1'b1};
        vt[6]  = '{3'b101, 32'h0,   32'h1,        32'h2,         32'h3,        1'b0};
        vt[7]  = '{3'b001, 32'h0,   32'h0,        32'h0,         32'h0,        1'b1};
        vt[8]  = '{3'b101, 32'h0,   32'hAB,       32'h0,         32'hAB,       1'b0};
        vt[9]  = '{3'b110, 32'h104, 32'h0,        32'h0,         32'h0,        1'b1};
        vt[10] = '{3'b101, 32'h0,   32'h7,        32'h0,         32'h7,        1'b0};
        vt[11] = '{3'b110, 32'h0FF, 32'h0,        32'h0,         32'h0,        1'b1};

        rst = 1'b1; clk_oe = 1'b1; disp_online = 1'b1; cmd_valid = 1'b0; mode = 3'b000;
        src0 = '0; src1 = '0; base_addr_data = '0; chan_base = 32'h100; msg_ready = 1'b1;
        in_valid = 1'b0; in_code = '0; in_addr = '0; in_data = '0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.dst", 0, dst, 32'h0);
        check("rst.done", 0, 32'(cmd_done), 32'h0);
        check("rst.err", 0, 32'(cmd_err), 32'h0);
        check("rst.msg_valid", 0, 32'(msg_valid), 32'h0);
        check("rst.msg_code", 0, 32'(msg_code), 32'h0);
        check("rst.ovf", 0, 32'(ovf), 32'h0);
        rst = 1'b1;

        // Buffered delivery in arrival order.
        inject(CHAN_SET, 32'h102, 32'hA1);
        inject(CHAN_SET, 32'h102, 32'hA2);
        inject(CHAN_SET, 32'h102, 32'hA3);
        run_cmd("recv2", 0, 3'b110, 32'h102, 0, 0, 32'hA1, 1'b0, 2);
        run_cmd("recv2", 1, 3'b110, 32'h102, 0, 0, 32'hA2, 1'b0, 2);
        run_cmd("recv2", 2, 3'b110, 32'h102, 0, 0, 32'hA3, 1'b0, 2);

        // Overflow on channel 0: fifth word is dropped.
        for (int i = 1; i <= 5; i++) inject(CHAN_SET, 32'h100, 32'(i));
        @(negedge clk);
        check("ovf.set", 0, 32'(ovf), 32'h1);

        // Single-cycle commands (nop at entry 1 clears ovf).
        for (int i = 0; i < 12; i++)
            run_cmd("vec", i, vt[i].m, vt[i].s0, vt[i].s1, vt[i].b, vt[i].dst, vt[i].err, 1);
        check("ovf.clr", 0, 32'(ovf), 32'h0);

        for (int i = 1; i <= 4; i++)
            run_cmd("drain0", i, 3'b110, 32'h100, 0, 0, 32'(i), 1'b0, 2);

        // Channel 0 is now empty: receive waits, then is aborted.
        @(negedge clk);
        mode = 3'b110; src0 = 32'h100; cmd_valid = 1'b1;
        early = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (cmd_done) early = 1'b1;
        end
        check("abort.wait", 0, 32'(early), 32'h0);
        disp_online = 1'b0;
        @(negedge clk);
        check("abort.done", 0, 32'(cmd_done), 32'h1);
        check("abort.err", 0, 32'(cmd_err), 32'h1);
        check("abort.dst", 0, dst, 32'h0);
        disp_online = 1'b1;
        cmd_valid = 1'b0;

        // Send with three cycles of withheld grant.
        @(negedge clk);
        msg_ready = 1'b0;
        mode = 3'b011; src0 = 32'h200; src1 = 32'h55; cmd_valid = 1'b1;
        held = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (msg_valid && !cmd_done) held++;
            if (i == 0) begin
                check("send.code", 0, 32'(msg_code), 32'(CHAN_SET));
                check("send.addr", 0, msg_addr, 32'h200);
                check("send.data", 0, msg_data, 32'h55);
            end
            if (i == 2) msg_ready = 1'b1;
        end
        check("send.held", 0, 32'(held), 32'd3);
        @(negedge clk);
        check("send.valid_drop", 0, 32'(msg_valid), 32'h0);
        check("send.done", 0, 32'(cmd_done), 32'h1);
        check("send.err", 0, 32'(cmd_err), 32'h0);
        check("send.code_idle", 0, 32'(msg_code), 32'h0);
        cmd_valid = 1'b0;

        // Query: grant immediately, reply pushed 5 cycles after the grant.
        @(negedge clk);
        mode = 3'b111; src0 = 32'h101; src1 = 32'h0; cmd_valid = 1'b1;
        @(negedge clk);
        check("query.valid", 0, 32'(msg_valid), 32'h1);
        check("query.addr", 0, msg_addr, 32'h101);
        early = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (cmd_done) early = 1'b1;
        end
        in_valid = 1'b1; in_code = CHAN_SET; in_addr = 32'h101; in_data = 32'h77;
        @(negedge clk);
        in_valid = 1'b0;
        if (cmd_done) early = 1'b1;
        check("query.wait", 0, 32'(early), 32'h0);
        @(negedge clk);
        check("query.done", 0, 32'(cmd_done), 32'h1);
        check("query.dst", 0, dst, 32'h77);
        check("query.err", 0, 32'(cmd_err), 32'h0);
        cmd_valid = 1'b0;

        // Disabled-clock hit and wrong-code message must not reach channel 3.
        @(negedge clk);
        clk_oe = 1'b0;
        in_valid = 1'b1; in_code = CHAN_SET; in_addr = 32'h103; in_data = 32'hBB;
        @(negedge clk);
        clk_oe = 1'b1;
        in_code = CHAN_SET + 8'h1; in_data = 32'hDD;
        @(negedge clk);
        in_code = CHAN_SET; in_data = 32'hCC;
        @(negedge clk);
        in_valid = 1'b0;
        run_cmd("oe_filter", 0, 3'b110, 32'h103, 0, 0, 32'hCC, 1'b0, 2);

        seen = (sb.size() == 0);
        check("sb.empty", 0, 32'(seen), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
